// File: rtl/cpu_param_pkg.sv
// rtl/cpu_param_pkg.sv - encoding fields, opcodes, shift codes and FSM states for cpu_param
package cpu_param_pkg;

  localparam int IMM_W = 8;

  localparam int OPC_HI = 15, OPC_LO = 13;
  localparam int OP_HI  = 12, OP_LO  = 11;
  localparam int RN_HI  = 10, RN_LO  = 8;
  localparam int RD_HI  = 7,  RD_LO  = 5;
  localparam int SH_HI  = 4,  SH_LO  = 3;
  localparam int RM_HI  = 2,  RM_LO  = 0;

  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [2:0] OPC_MOV = 3'b110;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_EXEC, S_WRITE
  } state_t;

  typedef enum logic [2:0] {
    ALU_MOV, ALU_ADD, ALU_CMP, ALU_AND, ALU_MVN
  } alu_t;

  function automatic logic is_legal(input logic [15:0] i);
    logic [2:0] opc;
    logic [1:0] op;
    opc = i[OPC_HI:OPC_LO];
    op  = i[OP_HI:OP_LO];
    return (opc == OPC_ALU) ||
           (opc == OPC_MOV && (op == OP_MOV_REG || op == OP_MOV_IMM));
  endfunction

endpackage

// File: rtl/cpu_param_fsm.sv
// rtl/cpu_param_fsm.sv - controller: state register, decode, datapath enables, w
// Optional sticky illegal-instruction flag under CPU_ILL_TRAP_EN.
module cpu_param_fsm
  import cpu_param_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic [15:0]      ir,
  output logic             w,
  output logic             ld_a,
  output logic             ld_b,
  output logic             ld_c,
  output logic             ld_flags,
  output logic             wr_en,
  output logic             wr_imm,
  output logic [2:0]       rsel,
  output logic [2:0]       wsel,
  output logic [2:0]       alu_sel,
  output logic [1:0]       shift,
  output logic [IMM_W-1:0] imm,
  output logic             ill
);

  state_t      state, nxt;
  alu_t        cls;
  logic [15:0] cir;

  // cir freezes the instruction at DECODE entry so later loads cannot disturb it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
      cir   <= '0;
    end else begin
      state <= nxt;
      if (state == S_WAIT && s) cir <= ir;
    end
  end

  always_comb begin
    cls = ALU_MOV;
    if (cir[OPC_HI:OPC_LO] == OPC_ALU) begin
      case (cir[OP_HI:OP_LO])
        OP_ADD:  cls = ALU_ADD;
        OP_CMP:  cls = ALU_CMP;
        OP_AND:  cls = ALU_AND;
        default: cls = ALU_MVN;
      endcase
    end
  end

  assign alu_sel = cls;
  assign shift   = cir[SH_HI:SH_LO];
  assign imm     = cir[IMM_W-1:0];

  always_comb begin
    nxt      = state;
    w        = 1'b0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    ld_c     = 1'b0;
    ld_flags = 1'b0;
    wr_en    = 1'b0;
    wr_imm   = 1'b0;
    rsel     = cir[RN_HI:RN_LO];
    wsel     = cir[RD_HI:RD_LO];
    case (state)
      S_WAIT: begin
        w = 1'b1;
        if (s) nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!is_legal(cir))                         nxt = S_WAIT;
        else if (cir[OPC_HI:OPC_LO] == OPC_MOV)
          nxt = (cir[OP_HI:OP_LO] == OP_MOV_IMM) ? S_WRITE_IMM : S_GET_B;
        else if (cls == ALU_MVN)                    nxt = S_GET_B;
        else                                        nxt = S_GET_A;
      end
      S_WRITE_IMM: begin
        wr_en  = 1'b1;
        wr_imm = 1'b1;
        wsel   = cir[RN_HI:RN_LO];
        nxt    = S_WAIT;
      end
      S_GET_A: begin
        ld_a = 1'b1;
        nxt  = S_GET_B;
      end
      S_GET_B: begin
        ld_b = 1'b1;
        rsel = cir[RM_HI:RM_LO];
        nxt  = S_EXEC;
      end
      S_EXEC: begin
        ld_c     = (cls != ALU_CMP);
        ld_flags = (cls != ALU_MOV);
        nxt      = (cls == ALU_CMP) ? S_WAIT : S_WRITE;
      end
      S_WRITE: begin
        wr_en = 1'b1;
        nxt   = S_WAIT;
      end
      default: nxt = S_WAIT;
    endcase
  end

`ifdef CPU_ILL_TRAP_EN
  logic ill_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               ill_q <= 1'b0;
    else if (state == S_DECODE && !is_legal(cir)) ill_q <= 1'b1;
  end
  assign ill = ill_q;
`else
  assign ill = 1'b0;
`endif

endmodule

// File: rtl/cpu_param.sv
// rtl/cpu_param.sv - width-parameterised multicycle RISC core: register file, shifter, ALU, flags
module cpu_param
  import cpu_param_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s,
  input  logic              load,
  input  logic [15:0]       in,
  output logic [DATA_W-1:0] out,
  output logic              N,
  output logic              V,
  output logic              Z,
  output logic              w,
  output logic              ill
);

  localparam int M = DATA_W - 1;

  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] a, b, c, shb, res, wdata, rdata;
  logic              n_q, v_q, z_q, vres;
  logic              ld_a, ld_b, ld_c, ld_flags, wr_en, wr_imm;
  logic [2:0]        rsel, wsel, alu_sel;
  logic [1:0]        shift;
  logic [IMM_W-1:0]  imm;

  cpu_param_fsm u_fsm (
    .clk(clk), .reset_n(reset_n), .s(s), .ir(ir), .w(w),
    .ld_a(ld_a), .ld_b(ld_b), .ld_c(ld_c), .ld_flags(ld_flags),
    .wr_en(wr_en), .wr_imm(wr_imm), .rsel(rsel), .wsel(wsel),
    .alu_sel(alu_sel), .shift(shift), .imm(imm), .ill(ill)
  );

  assign rdata = regs[rsel];
  assign wdata = wr_imm ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : c;

  always_comb begin
    shb = b;
    case (shift)
      SH_LSL:  shb = {b[M-1:0], 1'b0};
      SH_LSR:  shb = {1'b0, b[M:1]};
      SH_ASR:  shb = {b[M], b[M:1]};
      default: shb = b;
    endcase
  end

  // V is the classic sign-rule overflow; subtraction flips the operand-sign test
  always_comb begin
    res  = shb;
    vres = 1'b0;
    case (alu_sel)
      ALU_ADD: begin
        res  = a + shb;
        vres = (a[M] == shb[M]) && (res[M] != a[M]);
      end
      ALU_CMP: begin
        res  = a - shb;
        vres = (a[M] != shb[M]) && (res[M] != a[M]);
      end
      ALU_AND: res = a & shb;
      ALU_MVN: res = ~shb;
      default: res = shb;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir  <= '0;
      a   <= '0;
      b   <= '0;
      c   <= '0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (load) ir <= in;
      if (ld_a) a <= rdata;
      if (ld_b) b <= rdata;
      if (ld_c) c <= res;
      if (ld_flags) begin
        n_q <= res[M];
        v_q <= vres;
        z_q <= (res == '0);
      end
      if (wr_en) regs[wsel] <= wdata;
    end
  end

  assign out = c;
  assign N   = n_q;
  assign V   = v_q;
  assign Z   = z_q;

endmodule

// File: doc/cpu_param.md
Name: cpu_param

Overview:
Next-generation multicycle RISC core, generalised in datapath width (DATA_W). It keeps the existing 16-bit instruction encoding, eight general registers and the s/load/w start handshake. It adds a clearable register file, explicit flag-update rules and a sign-extended immediate that scales with width. It sits under the board top level in place of the fixed 16-bit cpu.

Parameters:
DATA_W, 16, datapath, register and out width; legal range 9..64.
IMM_W, 8, immediate field width; sign-extended to DATA_W; fixed by the encoding, not overridable.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
s  in  1  start; sampled only in state WAIT
load  in  1  loads instruction register from in on any posedge, any state
in  in  16  instruction word
out  out  DATA_W  C register (last ALU result)
N  out  1  negative flag
V  out  1  signed-overflow flag
Z  out  1  zero flag
w  out  1  high only in state WAIT
ill  out  1  sticky illegal-instruction flag (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0): state=WAIT, w=1, IR=0, R0..R7=0, A=B=C=0, out=0, N=V=Z=0, ill=0.
- Encoding: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm.
- Shift applied to Rm only: 00 none; 01 LSL1 (zero in); 10 LSR1 (zero in); 11 ASR1 (MSB copied).
- MOV imm (110,10): Rn <= sext(imm8). No flag change.
- MOV reg (110,00): Rd <= sh(Rm). No flag change.
- ADD (101,00): Rd <= Rn + sh(Rm).
- CMP (101,01): flags from Rn - sh(Rm); no register write.
- AND (101,10): Rd <= Rn & sh(Rm).
- MVN (101,11): Rd <= ~sh(Rm).
- Flags update only on ADD, CMP, AND and MVN, in EXEC.
  - Z: result == 0. N: result MSB.
  - V: signed two's-complement overflow for ADD and CMP; 0 for AND and MVN.
  - All arithmetic is modulo 2^DATA_W.
- FSM: WAIT -> DECODE (on s=1) -> branch by instruction class.
  - MOV imm: WRITE_IMM -> WAIT. w low for 2 cycles.
  - MOV reg: GET_B -> EXEC -> WRITE -> WAIT. w low for 4 cycles.
  - ADD/AND: GET_A -> GET_B -> EXEC -> WRITE -> WAIT. w low for 5 cycles.
  - MVN: GET_B -> EXEC -> WRITE -> WAIT. w low for 4 cycles.
  - CMP: GET_A -> GET_B -> EXEC -> WAIT. w low for 4 cycles.
- s outside WAIT is ignored; s held high in WAIT restarts immediately.
- Decode uses IR as latched at DECODE entry. A load during execution changes IR, but the in-flight instruction uses control already latched per state.
- Rd == Rn or Rd == Rm is legal: operands are read into A/B before WRITE.
- reset_n low mid-instruction aborts it; no partial register write is completed.
- Illegal encodings: opcodes other than 101/110, or 110 with op 01/11. These execute as NOP: DECODE -> WAIT, w low 1 cycle, no state change.

Optional Feature:
CPU_ILL_TRAP_EN
- Defined: an illegal encoding sets ill=1. ill stays high until reset_n and does not block further instructions.
- Undefined: ill is tied 0 and no trap logic is built. NOP behaviour is identical either way.

Decomposition:
- Package cpu_param_pkg: opcode and op localparams, shift codes, FSM state enum, field-slice constants.
- One natural sub-module: cpu_param_fsm (controller: state register, decode, datapath enables, w).
- Register file, shifter, ALU and flags stay in cpu_param.

Test Plan:
- DATA_W=16: MOV R0,#7; MOV R1,#2; ADD R2,R1,R0,LSL#1 -> R2=0x0010, N=V=Z=0, w low exactly 5 cycles on the ADD.
- MOV R0,#-1; MOV R0,R0 LSR#1 (0x7FFF); MOV R1,R0; ADD R2,R1,R0 -> R2=0xFFFE, N=1, V=1, Z=0.
- MOV R5,#85; MOV R6,R5 ASR#1 -> R6=42; MVN R7,R6 -> R7=0xFFD5, N=1; then MOV R5,#-69; MOV R6,R5 ASR#1 -> R6=0xFFDD, flags unchanged by the MOVs.
- MOV R5,#69; MOV R6,#69; CMP R6,R5 -> Z=1, N=0, V=0, R0..R7 unchanged; DATA_W=32 rerun: MOV R0,#-1 -> R0=0xFFFFFFFF.
- Assert reset_n=0 during EXEC of ADD R2 -> R2 unchanged-then-cleared to 0, w=1 immediately, out=0.
- in=0x0000 with s -> w low 1 cycle, ill=1 with CPU_ILL_TRAP_EN defined (0 without), registers unchanged.
